// File: rtl/ps2_host_tx.sv
// ---------------------------------------------------------------------------
// ps2_host_tx
//   Host-to-device PS/2 transmitter. Sends one command byte (e.g. 0xED
//   set-LEDs, 0xFF reset) from the system to the keyboard. Everything runs in
//   the system clock domain. The PS/2 clock and data pads are oversampled
//   through synchronisers. Both lines are driven open-drain: a drive output of
//   1 pulls the pad low, and 0 releases it.
//
//   Frame on the wire: start 0, d[0]..d[7] LSB first, odd parity, stop 1,
//   then the device's ack 0.
//
// Parameters
//   INHIBIT_CYCLES  system clocks the PS/2 clock is held low before the
//                   request-to-send (100 us at 50 MHz with the default)
//   TIMEOUT_CYCLES  maximum clocks from clock release to ack; only used
//                   when PS2_TX_TIMEOUT_EN is defined
//   SYNC_STAGES     synchroniser depth on ps2_nclk / ndata (minimum 2)
//
// Build option
//   PS2_TX_TIMEOUT_EN  when defined, a watchdog runs from REQ through ACK.
//                      It aborts a stalled transfer and pulses timeout.
//                      When undefined, timeout is tied to 0 and the block
//                      waits for the device indefinitely.
//
// Ports
//   Clk             system clock, rising edge
//   nReset          asynchronous active-low reset
//   tx_data[7:0]    byte to send, captured on tx_valid && tx_ready
//   tx_valid        send request
//   tx_ready        idle and able to accept a byte
//   ps2_nclk        sampled level of the PS/2 clock pad
//   ndata           sampled level of the PS/2 data pad
//   clk_drive_low   1 = pull PS/2 clock pad low
//   data_drive_low  1 = pull PS/2 data pad low
//   busy            high from byte acceptance until return to IDLE
//   done            one-cycle pulse: device acked the frame
//   ack_error       one-cycle pulse: device did not ack
//   timeout         one-cycle pulse: transfer aborted by the watchdog
// ---------------------------------------------------------------------------
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       Clk,
  input  logic       nReset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_nclk,
  input  logic       ndata,
  output logic       clk_drive_low,
  output logic       data_drive_low,
  output logic       busy,
  output logic       done,
  output logic       ack_error,
  output logic       timeout
);

  // Synchroniser depth is clamped to the metastability-safe minimum.
  localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  // The inhibit counter runs 0 .. INH_N-1.
  localparam int INH_N = (INHIBIT_CYCLES < 1) ? 1 : INHIBIT_CYCLES;
  localparam int INH_W = (INH_N > 1) ? $clog2(INH_N) : 1;
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INH_N - 1);
  // The start bit goes low one cycle before the clock is released. This
  // compare value wraps when INH_N == 1. That is harmless, because the last
  // cycle then also asserts the start bit.
  localparam logic [INH_W-1:0] INH_DATA = INH_W'(INH_N - 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQ,
    S_SHIFT,
    S_ACK,
    S_WAIT_IDLE
  } state_t;

  // -------------------------------------------------------------------------
  // Line synchronisers and fall detection
  // -------------------------------------------------------------------------
  logic [SYNC_N-1:0] clk_sync_q;
  logic [SYNC_N-1:0] dat_sync_q;
  logic              clk_prev_q;
  logic              clk_s;
  logic              dat_s;
  logic              fall;

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      clk_sync_q <= '1;
      dat_sync_q <= '1;
      clk_prev_q <= 1'b1;
    end else begin
      clk_sync_q <= {clk_sync_q[SYNC_N-2:0], ps2_nclk};
      dat_sync_q <= {dat_sync_q[SYNC_N-2:0], ndata};
      clk_prev_q <= clk_s;
    end
  end

  assign clk_s = clk_sync_q[SYNC_N-1];
  assign dat_s = dat_sync_q[SYNC_N-1];
  assign fall  = clk_prev_q & ~clk_s;

  // -------------------------------------------------------------------------
  // Transmit FSM
  // -------------------------------------------------------------------------
  state_t           state_q;
  logic [INH_W-1:0] inh_cnt_q;
  // The frame is shifted LSB first, with {stop, parity, d[7:0]} loaded at
  // accept. Ones are shifted in, so fall 10 naturally releases the line for
  // the stop bit.
  logic [9:0]       frame_q;
  logic [3:0]       bit_cnt_q;
  logic [3:0]       bit_cnt_d;
  logic             tx_ready_q;
  logic             busy_q;
  logic             clk_drive_low_q;
  logic             data_drive_low_q;
  logic             done_q;
  logic             ack_error_q;

`ifdef PS2_TX_TIMEOUT_EN
  localparam int TO_N = (TIMEOUT_CYCLES < 2) ? 2 : TIMEOUT_CYCLES;
  localparam int TO_W = $clog2(TO_N);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_N - 1);

  logic [TO_W-1:0] to_cnt_q;
  logic            timeout_q;
  logic            in_xfer;

  // The watchdog covers everything from clock release up to the ack.
  assign in_xfer = (state_q == S_REQ) || (state_q == S_SHIFT) ||
                   (state_q == S_ACK);
`endif

  assign bit_cnt_d = bit_cnt_q + 4'd1;

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state_q          <= S_IDLE;
      inh_cnt_q        <= '0;
      frame_q          <= '0;
      bit_cnt_q        <= '0;
      tx_ready_q       <= 1'b1;
      busy_q           <= 1'b0;
      clk_drive_low_q  <= 1'b0;
      data_drive_low_q <= 1'b0;
      done_q           <= 1'b0;
      ack_error_q      <= 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
      to_cnt_q         <= '0;
      timeout_q        <= 1'b0;
`endif
    end else begin
      done_q      <= 1'b0;
      ack_error_q <= 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
      timeout_q   <= 1'b0;
`endif

      case (state_q)
        S_IDLE: begin
          if (tx_valid) begin
            frame_q         <= {1'b1, ~^tx_data, tx_data};
            inh_cnt_q       <= '0;
            clk_drive_low_q <= 1'b1;
            tx_ready_q      <= 1'b0;
            busy_q          <= 1'b1;
            state_q         <= S_INHIBIT;
          end
        end

        // Clock is held low for INH_N cycles, counted from the accept edge.
        S_INHIBIT: begin
          if (inh_cnt_q == INH_LAST) begin
            clk_drive_low_q  <= 1'b0;
            data_drive_low_q <= 1'b1;
            state_q          <= S_REQ;
          end else begin
            if (inh_cnt_q == INH_DATA) begin
              data_drive_low_q <= 1'b1;
            end
            inh_cnt_q <= inh_cnt_q + INH_W'(1);
          end
        end

        // Falls seen before the clock was released must not count.
        S_REQ: begin
          bit_cnt_q <= '0;
          state_q   <= S_SHIFT;
        end

        S_SHIFT: begin
          if (fall) begin
            bit_cnt_q        <= bit_cnt_d;
            data_drive_low_q <= ~frame_q[0];
            frame_q          <= {1'b1, frame_q[9:1]};
            if (bit_cnt_d == 4'd10) begin
              state_q <= S_ACK;
            end
          end
        end

        // Fall 11: the device should be holding data low as its ack.
        S_ACK: begin
          if (fall) begin
            if (!dat_s) begin
              done_q <= 1'b1;
            end else begin
              ack_error_q <= 1'b1;
            end
            state_q <= S_WAIT_IDLE;
          end
        end

        S_WAIT_IDLE: begin
          if (clk_s && dat_s) begin
            tx_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            state_q    <= S_IDLE;
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase

`ifdef PS2_TX_TIMEOUT_EN
      // The counter is zero on REQ entry because it is cleared while idle.
      // If fall 11 lands on the expiry cycle, the ack wins and the timeout
      // is suppressed.
      if (state_q == S_IDLE) begin
        to_cnt_q <= '0;
      end else if (in_xfer) begin
        to_cnt_q <= to_cnt_q + TO_W'(1);
        if ((to_cnt_q == TO_LAST) && !((state_q == S_ACK) && fall)) begin
          clk_drive_low_q  <= 1'b0;
          data_drive_low_q <= 1'b0;
          timeout_q        <= 1'b1;
          state_q          <= S_WAIT_IDLE;
        end
      end
`endif
    end
  end

  assign tx_ready       = tx_ready_q;
  assign busy           = busy_q;
  assign clk_drive_low  = clk_drive_low_q;
  assign data_drive_low = data_drive_low_q;
  assign done           = done_q;
  assign ack_error      = ack_error_q;

`ifdef PS2_TX_TIMEOUT_EN
  assign timeout = timeout_q;
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_host_tx.sv
module tb_ps2_host_tx;

  localparam int INH = 20;
  localparam int TO  = 1000;

  logic       Clk      = 1'b0;
  logic       nReset   = 1'b0;
  logic [7:0] tx_data  = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       ps2_nclk;
  logic       ndata;
  logic       clk_drive_low;
  logic       data_drive_low;
  logic       busy;
  logic       done;
  logic       ack_error;
  logic       timeout;

  // Device side of the open-drain bus
  logic dev_clk_low  = 1'b0;
  logic dev_data_low = 1'b0;

  int checks = 0;
  int errors = 0;

  // Pulse / condition monitors
  int done_cnt = 0;
  int err_cnt  = 0;
  int to_cnt   = 0;
  int rwb_cnt  = 0;

  // Scoreboard of bits the device expects to sample
  bit exp_bits[$];
  int bit_idx;

  typedef struct {
    logic [7:0] data;
    bit         ack_low;
    bit         exp_parity;
    bit         exp_done;
    bit         exp_err;
    bit         poke;
  } vec_t;

  vec_t vecs[5];

  assign ps2_nclk = ~(clk_drive_low | dev_clk_low);
  assign ndata    = ~(data_drive_low | dev_data_low);

  always #5 Clk = ~Clk;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TO),
    .SYNC_STAGES(2)
  ) dut (
    .Clk(Clk),
    .nReset(nReset),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .ps2_nclk(ps2_nclk),
    .ndata(ndata),
    .clk_drive_low(clk_drive_low),
    .data_drive_low(data_drive_low),
    .busy(busy),
    .done(done),
    .ack_error(ack_error),
    .timeout(timeout)
  );

  always @(negedge Clk) begin
    if (done)             done_cnt <= done_cnt + 1;
    if (ack_error)        err_cnt  <= err_cnt + 1;
    if (timeout)          to_cnt   <= to_cnt + 1;
    if (busy && tx_ready) rwb_cnt  <= rwb_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic push_frame(input logic [7:0] b, input bit par);
    exp_bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_bits.push_back(b[i]);
    exp_bits.push_back(par);
    exp_bits.push_back(1'b1);
    bit_idx = 0;
  endtask

  task automatic sample_bit();
    bit e;
    if (exp_bits.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL sb_underflow actual=%0d required=empty-free", int'(ndata));
    end else begin
      e = exp_bits.pop_front();
      check($sformatf("frame_bit%0d", bit_idx), int'(ndata), int'(e));
    end
    bit_idx++;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge Clk);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge Clk);
    tx_valid = 1'b0;
  endtask

  // Called on the negedge after acceptance; returns clock-low length.
  task automatic measure_inhibit(output int n);
    n = 0;
    while (clk_drive_low && n < 4 * INH) begin
      @(negedge Clk);
      n++;
    end
  endtask

  // Device model: samples start at release, then clocks up to stop_after
  // falls, sampling after each rise; fall 11 carries the ack.
  task automatic dev_xfer(input bit ack_low, input int stop_after, input bit poke);
    repeat (3) @(negedge Clk);
    sample_bit();
    for (int k = 1; k <= 10 && k <= stop_after; k++) begin
      dev_clk_low = 1'b1;
      repeat (8) @(negedge Clk);
      dev_clk_low = 1'b0;
      if (poke && k == 3) begin
        tx_data  = 8'h55;
        tx_valid = 1'b1;
      end
      repeat (8) @(negedge Clk);
      if (poke && k == 3) tx_valid = 1'b0;
      sample_bit();
    end
    if (stop_after >= 11) begin
      dev_data_low = ack_low;
      repeat (4) @(negedge Clk);
      dev_clk_low = 1'b1;
      repeat (8) @(negedge Clk);
      dev_clk_low = 1'b0;
      repeat (4) @(negedge Clk);
      dev_data_low = 1'b0;
    end
  endtask

  task automatic wait_ready(output int w);
    w = 0;
    while (!tx_ready && w < 200) begin
      @(negedge Clk);
      w++;
    end
  endtask

  task automatic run_vec(input vec_t v);
    int n, w, d0, e0, r0;
    d0 = done_cnt;
    e0 = err_cnt;
    r0 = rwb_cnt;
    push_frame(v.data, v.exp_parity);
    send_byte(v.data);
    check("tx_ready_drop", int'(tx_ready), 0);
    check("busy_rise", int'(busy), 1);
    measure_inhibit(n);
    check("inhibit_len", n, INH);
    dev_xfer(v.ack_low, 11, v.poke);
    wait_ready(w);
    check("tx_ready_back", int'(tx_ready), 1);
    check("busy_fall", int'(busy), 0);
    check("done_pulses", done_cnt - d0, int'(v.exp_done));
    check("ack_err_pulses", err_cnt - e0, int'(v.exp_err));
    check("sb_empty", exp_bits.size(), 0);
    check("ready_while_busy", rwb_cnt - r0, 0);
    if (v.poke) begin
      repeat (30) @(negedge Clk);
      check("no_queued_send", int'(busy | clk_drive_low), 0);
    end
  endtask

  initial begin
    int n, w, d0, e0, t0;
    vec_t fin;

    vecs[0] = '{8'hED, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{8'h1C, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{8'hED, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{8'h80, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

    // Reset state
    repeat (3) @(negedge Clk);
    check("rst_tx_ready", int'(tx_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_clk_drv", int'(clk_drive_low), 0);
    check("rst_data_drv", int'(data_drive_low), 0);
    check("rst_status", int'({done, ack_error, timeout}), 0);
    nReset = 1'b1;
    repeat (5) @(negedge Clk);

    for (int i = 0; i < 5; i++) begin
      run_vec(vecs[i]);
      repeat (5) @(negedge Clk);
    end

    // Reset in the middle of SHIFT, after fall 4
    push_frame(8'hA5, 1'b1);
    send_byte(8'hA5);
    measure_inhibit(n);
    dev_xfer(1'b1, 4, 1'b0);
    d0 = done_cnt;
    e0 = err_cnt;
    check("pre_rst_data_drv", int'(data_drive_low), 1);
    dev_clk_low = 1'b1;
    @(negedge Clk);
    nReset = 1'b0;
    #1;
    check("midrst_clk_drv", int'(clk_drive_low), 0);
    check("midrst_data_drv", int'(data_drive_low), 0);
    check("midrst_tx_ready", int'(tx_ready), 1);
    exp_bits.delete();
    repeat (5) @(negedge Clk);
    dev_clk_low = 1'b0;
    nReset = 1'b1;
    repeat (10) @(negedge Clk);
    check("midrst_no_done", done_cnt - d0, 0);
    check("midrst_no_err", err_cnt - e0, 0);
    fin = '{8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    run_vec(fin);

    check("no_timeout_normal", to_cnt, 0);

    // Device never clocks
    repeat (5) @(negedge Clk);
    d0 = done_cnt;
    e0 = err_cnt;
    t0 = to_cnt;
    send_byte(8'h3C);
    measure_inhibit(n);
`ifdef PS2_TX_TIMEOUT_EN
    n = 0;
    while (!timeout && n < 3 * TO) begin
      @(negedge Clk);
      n++;
    end
    check("timeout_cycle", n, TO);
    check("to_clk_drv", int'(clk_drive_low), 0);
    check("to_data_drv", int'(data_drive_low), 0);
    wait_ready(w);
    check("to_tx_ready_back", int'(tx_ready), 1);
    check("to_pulses", to_cnt - t0, 1);
`else
    repeat (1500) @(negedge Clk);
    check("no_timeout_pulse", to_cnt - t0, 0);
    check("still_waiting", int'(busy), 1);
    nReset = 1'b0;
    repeat (3) @(negedge Clk);
    nReset = 1'b1;
    repeat (3) @(negedge Clk);
    check("recover_tx_ready", int'(tx_ready), 1);
`endif
    check("stall_no_done", done_cnt - d0, 0);
    check("stall_no_err", err_cnt - e0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter: sends one command byte (for example 0xED set-LEDs or 0xFF reset) from the system to the keyboard.
- Complements the existing device-to-host PS/2 serial receiver.
- Runs entirely in the system clock domain and oversamples the PS/2 clock and data lines.
- Drives both lines as open-drain, pull-low-only outputs; the top level ties them to the bidirectional pads.

Parameters:
- INHIBIT_CYCLES, default 5000: system clocks the PS/2 clock is held low before the request (100 us at 50 MHz).
- TIMEOUT_CYCLES, default 750000: maximum clocks allowed from clock release to ack (15 ms at 50 MHz); used only with PS2_TX_TIMEOUT_EN.
- SYNC_STAGES, default 2: synchroniser depth on ps2_nclk and ndata; minimum 2.

Ports:
- Clk, input, 1: system clock, rising edge.
- nReset, input, 1: asynchronous, active-low reset.
- tx_data, input, 8: byte to send; captured when tx_valid && tx_ready.
- tx_valid, input, 1: request to send tx_data.
- tx_ready, output, 1: high when idle and able to accept a byte.
- ps2_nclk, input, 1: sampled level of the PS/2 clock pad.
- ndata, input, 1: sampled level of the PS/2 data pad.
- clk_drive_low, output, 1: 1 = pull the PS/2 clock pad low, 0 = release.
- data_drive_low, output, 1: 1 = pull the PS/2 data pad low, 0 = release.
- busy, output, 1: high from byte acceptance until return to IDLE.
- done, output, 1: one-cycle pulse when a transfer is acked successfully.
- ack_error, output, 1: one-cycle pulse when the device does not ack.
- timeout, output, 1: one-cycle pulse when the transfer is aborted on the timer.

Behaviour:
- Reset (asynchronous): state = IDLE; clk_drive_low = 0; data_drive_low = 0; tx_ready = 1; busy = 0; done = 0; ack_error = 0; timeout = 0; bit counter = 0; synchronisers = all 1.
- Line sampling:
  - ps2_nclk and ndata pass through SYNC_STAGES flops.
  - fall = synchronised clock was 1 in the previous cycle and is 0 now.
- Frame: start 0, then d[0]..d[7] LSB first, then odd parity (= ~^tx_data), then stop 1, then the device's ack 0.
- IDLE:
  - tx_ready = 1.
  - On tx_valid: latch tx_data, compute parity, go to INHIBIT.
  - tx_ready drops and busy rises on the next cycle.
- INHIBIT:
  - clk_drive_low = 1 for INHIBIT_CYCLES cycles.
  - On the last cycle also set data_drive_low = 1 (start bit), then go to REQ.
- REQ:
  - clk_drive_low = 0, data_drive_low stays 1.
  - Bit counter = 0. Go to SHIFT.
- SHIFT: data changes only on fall.
  - Falls 1..8: data_drive_low = ~d[k-1].
  - Fall 9: data_drive_low = ~parity.
  - Fall 10: data_drive_low = 0 (stop bit, line released); go to ACK.
- ACK:
  - On fall 11, sample the synchronised ndata.
  - 0: pulse done. 1: pulse ack_error.
  - Either way, go to WAIT_IDLE.
- WAIT_IDLE:
  - Wait until the synchronised clock and data are both 1, then go to IDLE.
  - tx_ready reasserts on the next cycle.
- tx_valid while busy: ignored. The held byte is unaffected and there is no queueing.
- done, ack_error and timeout are mutually exclusive and occur at most once per transfer.
- Glitch-free outputs: clk_drive_low and data_drive_low are registered and change only on state or fall events.
- Reset mid-transfer: both drive outputs release immediately; any partial frame is abandoned and no status pulse is generated.
- A clock low left over before tx_valid does not count as a fall: the fall counter is cleared in REQ.

Optional Feature:
- PS2_TX_TIMEOUT_EN, defined:
  - A counter runs from entry to REQ.
  - If it reaches TIMEOUT_CYCLES before ACK completes: release both lines, pulse timeout, go to WAIT_IDLE.
  - Arrival of fall 11 on the same cycle as expiry gives precedence to fall 11.
- PS2_TX_TIMEOUT_EN, undefined: no counter is built, timeout is tied to 0, and the block waits for the device indefinitely.

Test Plan:
- Reset with nReset = 0 mid-SHIFT (after fall 4) -> clk_drive_low = 0, data_drive_low = 0, tx_ready = 1, no done pulse; a following send of 0xFF completes normally.
- INHIBIT_CYCLES = 20; send 0xED; device model clocks 11 falls with ack 0:
  - clk_drive_low is high for exactly 20 cycles.
  - Sampled bits at device rising edges are 0,1,0,1,1,0,1,1,1, parity 1, stop 1.
  - done pulses once; tx_ready returns after lines idle.
- Send 0x1C -> sampled bits 0,0,0,1,1,1,0,0,0, parity 0, stop 1; done = 1.
- Send 0x00 with device holding data high at fall 11 -> parity bit 1 observed, ack_error pulses, done stays 0.
- Assert tx_valid with 0x55 during an in-flight 0xED transfer -> 0x55 not sent, the 0xED frame is unchanged, tx_ready = 0 throughout.
- With PS2_TX_TIMEOUT_EN and TIMEOUT_CYCLES = 1000, device never clocks -> timeout pulses at cycle 1000 after REQ, both drives are 0, and the block returns to IDLE once lines are high; without the macro, timeout stays 0.
